// File: rtl/mw_adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multi-word adder sequencer:
//   state_t    - sequencer FSM state (IDLE / RUN / DONE), 2-bit encoding
//   ADD_N      - default width of one adder slice
//   ADD_WORDS  - default number of slices per addition
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADD_N     = 4;
   localparam int ADD_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : adder_pkg

// File: rtl/mw_adder_seq_if.sv
// -----------------------------------------------------------------------------
// mw_adder_seq_if
// Request/result bundle of the multi-word adder sequencer.
//   start     - request a new addition (honoured only while idle)
//   a, b      - W-bit operands, captured on the accepting edge
//   cin       - carry into the LSB slice, captured on the accepting edge
//   busy      - operation in progress (RUN or DONE)
//   done      - one-cycle pulse, result valid
//   sum, cout - registered result, held until the next result is produced
// Modports: master drives the request, slave is the sequencer.
// -----------------------------------------------------------------------------
interface mw_adder_seq_if
   import adder_pkg::*;
#(
   parameter int N     = ADD_N,
   parameter int WORDS = ADD_WORDS
);

   localparam int W = N * WORDS;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface : mw_adder_seq_if

// File: rtl/mw_adder_seq_slice.sv
// -----------------------------------------------------------------------------
// add_slice
// Purely combinational N-bit adder slice with carry in and carry out.
//   cin  - carry in
//   a, b - N-bit addends
//   cout - carry out
//   s    - N-bit sum
// -----------------------------------------------------------------------------
module add_slice #(
   parameter int N = 4
) (
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         cout,
   output logic [N-1:0] s
);

   // Zero-extend both addends so the carry lands in the extra MSB.
   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   end

endmodule : add_slice

// File: rtl/mw_adder_seq.sv
// -----------------------------------------------------------------------------
// mw_adder_seq
// Multi-cycle adder: streams a W = N*WORDS bit addition one N-bit slice per
// cycle, LSB slice first, through a single add_slice, registering the carry
// between slices.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mw_adder_seq_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// -----------------------------------------------------------------------------
module mw_adder_seq
   import adder_pkg::*;
#(
   parameter int N     = ADD_N,
   parameter int WORDS = ADD_WORDS
) (
   input  logic          clk,
   input  logic          rst_n,
   mw_adder_seq_if.slave bus
);

   localparam int W     = N * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t             r_state;
   state_t             w_state_next;

   logic [W-1:0]       r_a_sh;
   logic [W-1:0]       r_b_sh;
   logic [W-1:0]       r_sum_sh;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [W-1:0]       r_sum;
   logic               r_cout;

   logic [N-1:0]       w_slice_s;
   logic               w_slice_c;
   logic               w_last;
   logic [W-1:0]       w_sum_sh_next;

   // The single slice adder always works on the low slice of the shifters.
   add_slice #(.N(N)) u_slice (
      .cin  (r_carry),
      .a    (r_a_sh[N-1:0]),
      .b    (r_b_sh[N-1:0]),
      .cout (w_slice_c),
      .s    (w_slice_s)
   );

   assign w_last = (r_idx == IDX_W'(WORDS - 1));

   // New slice enters at the top; after WORDS shifts slice 0 sits at the LSB.
   // Written as shifts so WORDS=1 (W==N) needs no special case.
   assign w_sum_sh_next = (r_sum_sh >> N) | (W'(w_slice_s) << (W - N));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      w_state_next = r_state;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            bus.busy     = 1'b1;
            bus.done     = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Datapath. The visible result registers are loaded on the final RUN edge,
   // so they equal sum_sh/carry in DONE and then hold through the next
   // operation until its own final edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a_sh   <= bus.a;
                  r_b_sh   <= bus.b;
                  r_carry  <= bus.cin;
                  r_idx    <= '0;
                  r_sum_sh <= '0;
               end
            end
            RUN: begin
               r_a_sh   <= r_a_sh >> N;
               r_b_sh   <= r_b_sh >> N;
               r_sum_sh <= w_sum_sh_next;
               r_carry  <= w_slice_c;
               r_idx    <= r_idx + 1'b1;
               if (w_last) begin
                  r_sum  <= w_sum_sh_next;
                  r_cout <= w_slice_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule : mw_adder_seq

// File: tb/tb_mw_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_mw_adder_seq
// Directed bench for mw_adder_seq: a default instance (N=4, WORDS=4) and a
// single-slice instance (N=4, WORDS=1). Latency is counted in edges including
// the accepting edge, so a WORDS=4 result appears WORDS+1 = 5 edges in.
// -----------------------------------------------------------------------------
module tb_mw_adder_seq;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mw_adder_seq_if #(.N(4), .WORDS(4)) if0 ();
   mw_adder_seq_if #(.N(4), .WORDS(1)) if1 ();

   mw_adder_seq #(.N(4), .WORDS(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   mw_adder_seq #(.N(4), .WORDS(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   int n_vec  = 0;
   int n_err  = 0;
   int n_done = 0;
   int n_acc  = 0;

   // Count done pulses of the wide instance (one per DONE cycle).
   always @(posedge clk) begin
      if (if0.done === 1'b1) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the wide instance, checked against a+b+cin.
   task automatic run_op0(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input string tag);
      logic [16:0] exp;
      int edges;
      int bc;
      exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      if0.start = 1'b1;
      if0.a     = a;
      if0.b     = b;
      if0.cin   = cin;
      tick();
      n_acc++;
      if0.start = 1'b0;
      if0.a     = 16'($urandom);
      if0.b     = 16'($urandom);
      if0.cin   = 1'($urandom);
      edges = 1;
      bc    = 0;
      while (if0.done !== 1'b1 && edges < 20) begin
         if (if0.busy === 1'b1) bc++;
         tick();
         edges++;
      end
      if (if0.busy === 1'b1) bc++;
      check({tag, "_done"},    {31'd0, if0.done}, 32'd1);
      check({tag, "_latency"}, edges, 32'd5);
      check({tag, "_busy_cyc"}, bc, 32'd5);
      check({tag, "_sum"},     {16'd0, if0.sum}, {16'd0, exp[15:0]});
      check({tag, "_cout"},    {31'd0, if0.cout}, {31'd0, exp[16]});
      tick();
      check({tag, "_done_off"}, {31'd0, if0.done}, 32'd0);
      check({tag, "_idle"},     {31'd0, if0.busy}, 32'd0);
   endtask

   initial begin
      int edges;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;

      if0.start = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

      // Reset state
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", {31'd0, if0.busy}, 32'd0);
      check("rst_done", {31'd0, if0.done}, 32'd0);
      check("rst_sum",  {16'd0, if0.sum},  32'd0);
      check("rst_cout", {31'd0, if0.cout}, 32'd0);
      check("rst_sum1", {28'd0, if1.sum},  32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Directed vectors
      run_op0(16'hFFFF, 16'h0001, 1'b0, "ffff_p1");     // 0x0000, cout 1
      run_op0(16'h1234, 16'h4321, 1'b1, "1234_4321");   // 0x5556, cout 0
      check("v2_sum", {16'd0, if0.sum}, 32'h5556);
      run_op0(16'h8000, 16'h8000, 1'b0, "8000_8000");   // 0x0000, cout 1
      check("v3_cout", {31'd0, if0.cout}, 32'd1);

      // start held high: only IDLE edges accept, operands from those edges
      if0.start = 1'b1;
      if0.a = 16'h1111; if0.b = 16'h2222; if0.cin = 1'b0;
      tick();
      n_acc++;
      if0.a = 16'hFFFF; if0.b = 16'hFFFF; if0.cin = 1'b1;
      edges = 1;
      while (if0.done !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      check("hold1_latency", edges, 32'd5);
      check("hold1_sum",  {16'd0, if0.sum},  32'h3333);
      check("hold1_cout", {31'd0, if0.cout}, 32'd0);
      if0.a = 16'h0F0F; if0.b = 16'h0101; if0.cin = 1'b1;
      tick();   // DONE -> IDLE, start ignored here
      check("hold_idle_busy", {31'd0, if0.busy}, 32'd0);
      check("hold_idle_done", {31'd0, if0.done}, 32'd0);
      tick();   // accepted in IDLE
      n_acc++;
      check("hold2_busy", {31'd0, if0.busy}, 32'd1);
      if0.start = 1'b0;
      if0.a = 16'hDEAD; if0.b = 16'hBEEF; if0.cin = 1'b0;
      edges = 1;
      while (if0.done !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      check("hold2_latency", edges, 32'd5);
      check("hold2_sum",  {16'd0, if0.sum},  32'h1011);
      check("hold2_cout", {31'd0, if0.cout}, 32'd0);
      tick();

      // Reset two cycles into RUN aborts; outputs clear asynchronously
      if0.start = 1'b1;
      if0.a = 16'h1234; if0.b = 16'h4321; if0.cin = 1'b1;
      tick();
      if0.start = 1'b0;
      tick();
      tick();
      check("abort_busy_pre", {31'd0, if0.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, if0.busy}, 32'd0);
      check("abort_done", {31'd0, if0.done}, 32'd0);
      check("abort_sum",  {16'd0, if0.sum},  32'd0);
      check("abort_cout", {31'd0, if0.cout}, 32'd0);
      repeat (8) tick();
      rst_n = 1'b1;
      tick();
      check("abort_no_done", n_done, n_acc);
      run_op0(16'h1234, 16'h4321, 1'b1, "post_abort");

      // Single-slice instance: 0xF + 0xF + 1 = 0x1F
      if1.start = 1'b1; if1.a = 4'hF; if1.b = 4'hF; if1.cin = 1'b1;
      tick();
      if1.start = 1'b0; if1.a = 4'h0; if1.b = 4'h0; if1.cin = 1'b0;
      edges = 1;
      while (if1.done !== 1'b1 && edges < 10) begin
         tick();
         edges++;
      end
      check("w1_latency", edges, 32'd2);
      check("w1_sum",  {28'd0, if1.sum},  32'hF);
      check("w1_cout", {31'd0, if1.cout}, 32'd1);
      tick();
      check("w1_done_off", {31'd0, if1.done}, 32'd0);

      // Random operands with random idle gaps
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         run_op0(ra, rb, rc, "rnd");
      end

      check("done_per_start", n_done, n_acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mw_adder_seq
